// File: rtl/rails_pkg.sv
// Shared constants, FSM state encoding and op encoding for the rails stimulus generator.
package rails_pkg;
  localparam int MAX_N = 10;
  localparam int W     = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIM  = 3'd1,
    HEAD = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;
endpackage

// File: rtl/rails_stack.sv
// LIFO modelling the station siding; rdata always shows the current top of stack.
module rails_stack #(
  parameter int DEPTH = rails_pkg::MAX_N,
  parameter int W     = rails_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  import rails_pkg::*;

  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] top_idx;

  always_comb begin
    empty   = (sp == '0);
    full    = (sp == SP_W'(DEPTH));
    top_idx = sp - SP_W'(1);
    rdata   = mem[top_idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/rails_gen.sv
// Simulates the station for a push/pop string and streams header n plus departure order.
// Optional RAILS_GEN_CORRUPT_EN: swap the last two cars on request to build negative patterns.
module rails_gen #(
  parameter int MAX_N = rails_pkg::MAX_N,
  parameter int W     = rails_pkg::W,
  parameter int OPS_W = 2 * MAX_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     n,
  input  logic [OPS_W-1:0] ops,
  input  logic             corrupt,
  output logic             busy,
  output logic [W-1:0]     data,
  output logic             data_en,
  output logic             done,
  output logic             error
);
  import rails_pkg::*;

  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int OPI_W = (OPS_W > 1) ? $clog2(OPS_W) : 1;
  localparam logic [W:0] ONE = (W+1)'(1);
  localparam logic [W:0] TWO = (W+1)'(2);

  state_t           state;
  logic [W-1:0]     n_q;
  logic [OPS_W-1:0] ops_q;
  logic [W:0]       cnt;
  logic [W:0]       op_idx;
  logic [W:0]       out_idx;
  logic [W-1:0]     out_buf [MAX_N];

  logic             stk_push, stk_pop, stk_clear, stk_empty, full_unused;
  logic [W-1:0]     stk_rdata;
  logic             cur_op, push_ok, pop_ok, last_op, ends_empty, op_bad, accept;
  logic [W:0]       n_x, last_idx;
  logic             corrupt_active;

`ifdef RAILS_GEN_CORRUPT_EN
  logic corrupt_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      corrupt_q <= corrupt;
    end
  end

  assign corrupt_active = corrupt_q && (n_x >= TWO);
`else
  logic unused_corrupt;
  assign unused_corrupt = corrupt;
  assign corrupt_active = 1'b0;
`endif

  // Maps stream position k to the out_buf slot; a corrupt run trades the last two slots.
  function automatic logic [IDX_W-1:0] emit_sel(input logic [W:0] k, input logic [W:0] nn,
                                                input logic cor);
    logic [W:0] s;
    s = k;
    if (cor) begin
      if (k == nn - TWO)      s = nn - ONE;
      else if (k == nn - ONE) s = nn - TWO;
    end
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    n_x        = {1'b0, n_q};
    last_idx   = {n_q, 1'b0} - ONE;
    cur_op     = ops_q[op_idx[OPI_W-1:0]];
    push_ok    = (cnt <= n_x);
    pop_ok     = !stk_empty;
    last_op    = (op_idx == last_idx);
    op_bad     = (cur_op == OP_PUSH) ? !push_ok : !pop_ok;
    // pushed = cnt-1, popped = out_idx; a final pop empties the siding iff one car remained
    ends_empty = (cur_op == OP_POP) && (cnt == out_idx + TWO);
    accept     = (state == IDLE) && start;
    stk_clear  = accept;
    stk_push   = (state == SIM) && (cur_op == OP_PUSH) && push_ok;
    stk_pop    = (state == SIM) && (cur_op == OP_POP) && pop_ok;
  end

  rails_stack #(.DEPTH(MAX_N), .W(W)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .clear (stk_clear),
    .wdata (cnt[W-1:0]),
    .rdata (stk_rdata),
    .empty (stk_empty),
    .full  (full_unused)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      n_q   <= n;
      ops_q <= ops;
    end
    if (stk_pop) begin
      out_buf[out_idx[IDX_W-1:0]] <= stk_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      data_en <= 1'b0;
      data    <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
      cnt     <= '0;
      op_idx  <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (start) begin
            cnt     <= ONE;
            op_idx  <= '0;
            out_idx <= '0;
            if (n == '0 || n > W'(MAX_N)) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= SIM;
              busy  <= 1'b1;
            end
          end
        end
        SIM: begin
          if (op_bad || (last_op && !ends_empty)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            if (cur_op == OP_PUSH) cnt <= cnt + ONE;
            else                   out_idx <= out_idx + ONE;
            op_idx <= op_idx + ONE;
            if (last_op) begin
              state   <= HEAD;
              data_en <= 1'b1;
              data    <= n_q;
              out_idx <= '0;
            end
          end
        end
        HEAD: begin
          data    <= out_buf[emit_sel('0, n_x, corrupt_active)];
          out_idx <= ONE;
          state   <= EMIT;
        end
        EMIT: begin
          if (out_idx == n_x) begin
            state   <= DONE;
            data_en <= 1'b0;
            data    <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            error   <= 1'b0;
          end else begin
            data    <= out_buf[emit_sel(out_idx, n_x, corrupt_active)];
            out_idx <= out_idx + ONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          error <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rails_gen.sv
// Directed bench for rails_gen: a queue-based station model predicts every output cycle by cycle.
module tb_rails_gen;
  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  n_i;
  logic [19:0] ops_i;
  logic        corrupt_i;
  logic        busy;
  logic [3:0]  data;
  logic        data_en;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  int exp_n, exp_d, exp_err;
  int exp_stream[$];
  int run_id = 0, seen_id = 0, done_id = 0, off = 0;

  rails_gen dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .n       (n_i),
    .ops     (ops_i),
    .corrupt (corrupt_i),
    .busy    (busy),
    .data    (data),
    .data_en (data_en),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Station model: returns departure list, error flag and the cycle offset of done.
  task automatic model(input int nn, input logic [19:0] op, input bit cor);
    int stk[$];
    int nxt;
    int tmp;
    nxt = 1;
    exp_stream.delete();
    exp_err = 0;
    exp_n   = nn;
    if (nn < 1 || nn > 10) begin
      exp_err = 1;
      exp_d   = 1;
      return;
    end
    for (int i = 0; i < 2 * nn; i++) begin
      if (op[i]) begin
        if (nxt > nn) begin
          exp_err = 1; exp_d = i + 2; return;
        end
        stk.push_back(nxt);
        nxt++;
      end else begin
        if (stk.size() == 0) begin
          exp_err = 1; exp_d = i + 2; return;
        end
        exp_stream.push_back(stk.pop_back());
      end
    end
    if (stk.size() != 0) begin
      exp_err = 1; exp_d = 2 * nn + 1; return;
    end
`ifdef RAILS_GEN_CORRUPT_EN
    if (cor && nn >= 2) begin
      tmp = exp_stream[nn-1];
      exp_stream[nn-1] = exp_stream[nn-2];
      exp_stream[nn-2] = tmp;
    end
`else
    tmp = cor ? 1 : 0;
`endif
    exp_d = 3 * nn + 2;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic run(input int nn, input logic [19:0] op, input bit cor, input bit poke);
    @(negedge clk);
    n_i = 4'(nn); ops_i = op; corrupt_i = cor; start = 1'b1;
    model(nn, op, cor);
    @(posedge clk); #1;
    if (poke) begin
      n_i = 4'd1; ops_i = 20'h1; corrupt_i = 1'b0;
    end else begin
      start = 1'b0;
    end
    run_id++;
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < 200; c++) begin
      if (done_id == run_id) break;
      @(posedge clk);
    end
    if (done_id != run_id) begin
      tests++; fails++;
      $display("FAIL timeout run=%0d got done_id %0d want %0d", run_id, done_id, run_id);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; n_i = '0; ops_i = '0; corrupt_i = 1'b0;

    fork
      begin
        forever begin
          bit e_busy, e_en, e_done;
          int e_data;
          @(negedge clk);
          if (run_id != seen_id) begin
            seen_id = run_id;
            off = 0;
          end
          if (seen_id != done_id) begin
            off++;
            e_done = (off == exp_d);
            e_busy = (off < exp_d);
            e_en   = (exp_err == 0) && (off >= 2 * exp_n + 1) && (off <= 3 * exp_n + 1);
            e_data = 0;
            if (e_en) e_data = (off == 2 * exp_n + 1) ? exp_n : exp_stream[off - 2 * exp_n - 2];
            tests++;
            if (busy !== e_busy || data_en !== e_en || int'(data) != e_data ||
                done !== e_done || (e_done && error !== exp_err[0])) begin
              fails++;
              $display("FAIL cycle run=%0d off=%0d got busy/en/data/done/err=%0b/%0b/%0d/%0b/%0b want %0b/%0b/%0d/%0b/%0b",
                       seen_id, off, busy, data_en, data, done, error,
                       e_busy, e_en, e_data, e_done, exp_err);
            end
            if (off >= exp_d + 2) done_id = seen_id;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_en", int'(data_en), 0);
    chk("reset_data", int'(data), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    reset = 1'b0;

    run(3, 20'b010101, 1'b0, 1'b0);
    chk("alt_s0", exp_stream[0], 1);
    chk("alt_s1", exp_stream[1], 2);
    chk("alt_s2", exp_stream[2], 3);
    chk("alt_done_off", exp_d, 11);

    run(3, 20'b000111, 1'b0, 1'b1);
    chk("rev_s0", exp_stream[0], 3);
    chk("rev_s2", exp_stream[2], 1);

    run(2, 20'b1100, 1'b0, 1'b0);
    chk("popempty_err", exp_err, 1);
    chk("popempty_off", exp_d, 2);

    run(0, 20'b01, 1'b0, 1'b1);
    chk("n0_off", exp_d, 1);
    run(11, 20'h55555, 1'b0, 1'b1);
    chk("n11_err", exp_err, 1);

    run(3, 20'b000111, 1'b1, 1'b0);
`ifdef RAILS_GEN_CORRUPT_EN
    chk("corrupt_s1", exp_stream[1], 1);
    chk("corrupt_s2", exp_stream[2], 2);
`else
    chk("corrupt_s1", exp_stream[1], 2);
    chk("corrupt_s2", exp_stream[2], 1);
`endif

    run(2, 20'b0111, 1'b0, 1'b0);
    chk("overpush_off", exp_d, 4);
    run(1, 20'b01, 1'b0, 1'b0);
    run(10, 20'h003FF, 1'b0, 1'b0);
    chk("n10_s0", exp_stream[0], 10);
    chk("n10_off", exp_d, 32);
    run(2, 20'hFFFF5, 1'b0, 1'b0);
    chk("upper_ignored_err", exp_err, 0);

    @(negedge clk);
    n_i = 4'd3; ops_i = 20'b000111; corrupt_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_en", int'(data_en), 1);
    chk("mid_data", int'(data), 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_en", int'(data_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_data", int'(data), 0);
    chk("midrst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle_busy", int'(busy), 0);

    run(4, 20'b01001011, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
